// File: rtl/board_pkg.sv
// Shared definitions for the board mode sequencer: mode indices, search direction,
// sequencer state and a one-hot helper.
package board_pkg;

    localparam int unsigned MAX_MODES       = 16;
    localparam int unsigned MODE_KEYBOARD   = 0;
    localparam int unsigned MODE_WORDBOARD  = 1;
    localparam int unsigned MODE_TWEETBOARD = 2;

    typedef enum logic {
        DirNext = 1'b0,
        DirPrev = 1'b1
    } search_dir_e;

    typedef enum logic {
        StRun   = 1'b0,
        StBlank = 1'b1
    } seq_state_e;

    function automatic logic [MAX_MODES-1:0] onehot(input logic [3:0] idx);
        logic [MAX_MODES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Control/status bundle between the board top level and the mode sequencer.
interface mode_sequencer_if #(
    parameter int unsigned NUM_MODES = 3
);
    localparam int unsigned IDX_W = $clog2(NUM_MODES);

    logic                 step_next;
    logic                 step_prev;
    logic                 sel_load;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_MODES-1:0] mode_en;
    logic [NUM_MODES-1:0] mode_out;
    logic [NUM_MODES-1:0] active;
    logic [NUM_MODES-1:0] leds;
    logic                 out_final;
    logic                 busy;
    logic                 sel_err;

    modport master (
        output step_next, step_prev, sel_load, sel_idx, mode_en, mode_out,
        input  active, leds, out_final, busy, sel_err
    );

    modport slave (
        input  step_next, step_prev, sel_load, sel_idx, mode_en, mode_out,
        output active, leds, out_final, busy, sel_err
    );

endinterface

// File: rtl/mode_sequencer_search.sv
// Combinational search for the nearest enabled mode after (next) or before (prev) cur,
// wrapping; cur itself is the last candidate so a re-enabled cur can be found.
module mode_search
    import board_pkg::*;
#(
    parameter int unsigned NUM_MODES = 3,
    parameter int unsigned IDX_W     = $clog2(NUM_MODES)
) (
    input  logic [IDX_W-1:0]     i_cur,
    input  logic [NUM_MODES-1:0] i_mode_en,
    input  search_dir_e          i_dir,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_target
);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest enabled mode overwrites last.
    always_comb begin
        o_found  = 1'b0;
        o_target = i_cur;
        w_idx    = 0;
        for (int k = int'(NUM_MODES); k >= 1; k--) begin
            if (i_dir == DirNext) begin
                w_idx = (int'(i_cur) + k) % int'(NUM_MODES);
            end else begin
                w_idx = (int'(i_cur) + int'(NUM_MODES) - k) % int'(NUM_MODES);
            end
            if (i_mode_en[IDX_W'(w_idx)]) begin
                o_found  = 1'b1;
                o_target = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Owns the live-mode index for NUM_MODES sub-boards: stepping, direct select, enable
// mask handling, break-before-make blanking and the registered serial output mux.
module mode_sequencer
    import board_pkg::*;
#(
    parameter int unsigned NUM_MODES    = 3,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned IDX_W        = $clog2(NUM_MODES)
) (
    input  logic             i_sysclk,
    input  logic             i_rst_n,
    mode_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int unsigned SEL_W = 2 ** IDX_W;

    seq_state_e           r_state, w_state_d;
    logic [IDX_W-1:0]     r_cur, w_cur_d;
    logic [NUM_MODES-1:0] r_active, w_active_d;
    logic [NUM_MODES-1:0] r_leds, w_leds_d;
    logic [CNT_W-1:0]     r_blank_cnt, w_blank_cnt_d;
    logic                 r_out_final, w_out_final_d;
    logic                 r_sel_err, w_sel_err_d;
    logic                 r_step_q, r_prev_q;

    logic                 w_next_edge, w_prev_edge;
    logic                 w_next_found, w_prev_found;
    logic [IDX_W-1:0]     w_next_target, w_prev_target;
    logic [SEL_W-1:0]     w_en_pad;
    logic                 w_sel_ok, w_cur_en, w_auto;
    logic                 w_switch;
    logic [IDX_W-1:0]     w_target;

    function automatic logic [NUM_MODES-1:0] mode_oh(input logic [IDX_W-1:0] idx);
        logic [MAX_MODES-1:0] full;
        full = onehot(4'(idx));
        return full[NUM_MODES-1:0];
    endfunction

    mode_search #(
        .NUM_MODES (NUM_MODES),
        .IDX_W     (IDX_W)
    ) u_search_next (
        .i_cur     (r_cur),
        .i_mode_en (bus.mode_en),
        .i_dir     (DirNext),
        .o_found   (w_next_found),
        .o_target  (w_next_target)
    );

    mode_search #(
        .NUM_MODES (NUM_MODES),
        .IDX_W     (IDX_W)
    ) u_search_prev (
        .i_cur     (r_cur),
        .i_mode_en (bus.mode_en),
        .i_dir     (DirPrev),
        .o_found   (w_prev_found),
        .o_target  (w_prev_target)
    );

    assign w_next_edge = bus.step_next & ~r_step_q;
    assign w_prev_edge = bus.step_prev & ~r_prev_q;
    assign w_en_pad    = SEL_W'(bus.mode_en);
    assign w_sel_ok    = (32'(bus.sel_idx) < NUM_MODES) && w_en_pad[bus.sel_idx];
    assign w_cur_en    = bus.mode_en[r_cur];
    // All-zero active outside blanking means no mode was enabled; recover via next-search.
    assign w_auto      = !w_cur_en || (r_active == '0);

    always_comb begin
        w_state_d     = r_state;
        w_cur_d       = r_cur;
        w_active_d    = r_active;
        w_leds_d      = r_leds;
        w_blank_cnt_d = r_blank_cnt;
        w_sel_err_d   = 1'b0;
        w_switch      = 1'b0;
        w_target      = r_cur;

        if (r_state == StBlank) begin
            if (r_blank_cnt <= CNT_W'(1)) begin
                w_active_d    = mode_oh(r_cur);
                w_state_d     = StRun;
                w_blank_cnt_d = '0;
            end else begin
                w_blank_cnt_d = r_blank_cnt - CNT_W'(1);
            end
        end else begin
            w_sel_err_d = bus.sel_load && !w_sel_ok;
            if (bus.sel_load && w_sel_ok && (bus.sel_idx != r_cur)) begin
                w_switch = 1'b1;
                w_target = bus.sel_idx;
            end else if (w_auto) begin
                if (w_next_found) begin
                    w_switch = 1'b1;
                    w_target = w_next_target;
                end else begin
                    w_active_d = '0;
                    w_leds_d   = '0;
                end
            end else if (bus.sel_load) begin
                // Rejected or same-index select: nothing beyond the error pulse.
            end else if (w_next_edge && !w_prev_edge) begin
                if (w_next_found && (w_next_target != r_cur)) begin
                    w_switch = 1'b1;
                    w_target = w_next_target;
                end
            end else if (w_prev_edge && !w_next_edge) begin
                if (w_prev_found && (w_prev_target != r_cur)) begin
                    w_switch = 1'b1;
                    w_target = w_prev_target;
                end
            end
        end

        if (w_switch) begin
            w_cur_d  = w_target;
            w_leds_d = mode_oh(w_target);
            if (BLANK_CYCLES == 0) begin
                w_active_d = mode_oh(w_target);
            end else begin
                w_active_d    = '0;
                w_state_d     = StBlank;
                w_blank_cnt_d = CNT_W'(BLANK_CYCLES);
            end
        end

        w_out_final_d = (|w_active_d) ? bus.mode_out[w_cur_d] : 1'b0;
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StRun;
            r_cur       <= '0;
            r_active    <= NUM_MODES'(1);
            r_leds      <= NUM_MODES'(1);
            r_blank_cnt <= '0;
            r_out_final <= 1'b0;
            r_sel_err   <= 1'b0;
            r_step_q    <= 1'b0;
            r_prev_q    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cur       <= w_cur_d;
            r_active    <= w_active_d;
            r_leds      <= w_leds_d;
            r_blank_cnt <= w_blank_cnt_d;
            r_out_final <= w_out_final_d;
            r_sel_err   <= w_sel_err_d;
            r_step_q    <= bus.step_next;
            r_prev_q    <= bus.step_prev;
        end
    end

    assign bus.active    = r_active;
    assign bus.leds      = r_leds;
    assign bus.out_final = r_out_final;
    assign bus.busy      = (r_state == StBlank);
    assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed table-driven bench for mode_sequencer (3 modes, 4-cycle blank) plus a
// zero-blank instance for the direct-switch case.
module tb_mode_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mode_sequencer_if #(.NUM_MODES(3)) bus ();
    mode_sequencer_if #(.NUM_MODES(3)) bus0 ();

    mode_sequencer #(
        .NUM_MODES    (3),
        .BLANK_CYCLES (4)
    ) u_dut (
        .i_sysclk (clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    mode_sequencer #(
        .NUM_MODES    (3),
        .BLANK_CYCLES (0)
    ) u_dut0 (
        .i_sysclk (clk),
        .i_rst_n  (rst_n),
        .bus      (bus0)
    );

    typedef struct {
        logic       nx, pv, ld;
        logic [1:0] idx;
        logic [2:0] en, mo;
        logic [2:0] act, led;
        logic       of, bsy, err;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_bad   = 0;

    function automatic void add(int nx, int pv, int ld, int idx, int en, int mo,
                                int act, int led, int of, int bsy, int err);
        vec_t v;
        v.nx  = 1'(nx);
        v.pv  = 1'(pv);
        v.ld  = 1'(ld);
        v.idx = 2'(idx);
        v.en  = 3'(en);
        v.mo  = 3'(mo);
        v.act = 3'(act);
        v.led = 3'(led);
        v.of  = 1'(of);
        v.bsy = 1'(bsy);
        v.err = 1'(err);
        vecs.push_back(v);
    endfunction

    // Three more blanked cycles after the switch row, then the cycle active returns.
    function automatic void tail(int en, int mo, int led, int of_end);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, en, mo, 0, led, 0, 1, 0);
        add(0, 0, 0, 0, en, mo, led, led, of_end, 0, 0);
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] got,
                       input logic [15:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        bus.step_next = v.nx;
        bus.step_prev = v.pv;
        bus.sel_load  = v.ld;
        bus.sel_idx   = v.idx;
        bus.mode_en   = v.en;
        bus.mode_out  = v.mo;
        @(posedge clk);
        #1;
        chk("active", row, 16'(bus.active), 16'(v.act));
        chk("leds", row, 16'(bus.leds), 16'(v.led));
        chk("out_final", row, 16'(bus.out_final), 16'(v.of));
        chk("busy", row, 16'(bus.busy), 16'(v.bsy));
        chk("sel_err", row, 16'(bus.sel_err), 16'(v.err));
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.step_next  = 1'b0;
        bus.step_prev  = 1'b0;
        bus.sel_load   = 1'b0;
        bus.sel_idx    = 2'd0;
        bus.mode_en    = 3'b111;
        bus.mode_out   = 3'b000;
        bus0.step_next = 1'b0;
        bus0.step_prev = 1'b0;
        bus0.sel_load  = 1'b0;
        bus0.sel_idx   = 2'd0;
        bus0.mode_en   = 3'b111;
        bus0.mode_out  = 3'b000;

        #12;
        chk("rst_active", -1, 16'(bus.active), 16'h1);
        chk("rst_leds", -1, 16'(bus.leds), 16'h1);
        chk("rst_out_final", -1, 16'(bus.out_final), 16'h0);
        chk("rst_busy", -1, 16'(bus.busy), 16'h0);
        chk("rst_sel_err", -1, 16'(bus.sel_err), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // nx pv ld idx en mo | act led of busy err
        add(0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 7, 0, 0, 2, 0, 1, 0); tail(7, 0, 2, 0);
        add(1, 0, 0, 0, 7, 0, 0, 4, 0, 1, 0); tail(7, 0, 4, 0);
        add(1, 0, 0, 0, 7, 0, 0, 1, 0, 1, 0); tail(7, 0, 1, 0);
        // sparse mask 101
        add(1, 0, 0, 0, 5, 0, 0, 4, 0, 1, 0); tail(5, 0, 4, 0);
        add(0, 1, 0, 0, 5, 0, 0, 1, 0, 1, 0); tail(5, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        // direct select
        add(0, 0, 1, 3, 7, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 2, 3, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 7, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 2, 7, 0, 0, 4, 0, 1, 0); tail(7, 0, 4, 0);
        // simultaneous requests and edges while busy
        add(1, 1, 0, 0, 7, 0, 4, 4, 0, 0, 0);
        add(0, 0, 0, 0, 7, 0, 4, 4, 0, 0, 0);
        add(0, 0, 1, 0, 7, 0, 0, 1, 0, 1, 0); tail(7, 0, 1, 0);
        add(1, 0, 1, 2, 7, 0, 0, 4, 0, 1, 0);
        add(0, 0, 0, 0, 7, 0, 0, 4, 0, 1, 0);
        add(1, 0, 0, 0, 7, 0, 0, 4, 0, 1, 0);
        add(0, 0, 0, 0, 7, 0, 0, 4, 0, 1, 0);
        add(0, 0, 0, 0, 7, 0, 4, 4, 0, 0, 0);
        add(0, 0, 0, 0, 7, 0, 4, 4, 0, 0, 0);
        // current mode disabled, then nothing enabled, then recovery
        add(0, 0, 1, 1, 7, 0, 0, 2, 0, 1, 0); tail(7, 0, 2, 0);
        add(0, 0, 0, 0, 5, 0, 0, 4, 0, 1, 0); tail(5, 0, 4, 0);
        add(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0); tail(1, 0, 1, 0);
        // serial output mux
        add(0, 0, 0, 0, 7, 1, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 7, 1, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 7, 6, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 7, 7, 0, 2, 0, 1, 0); tail(7, 7, 2, 1);
        add(0, 0, 0, 0, 7, 5, 2, 2, 0, 0, 0);
        add(0, 0, 0, 0, 7, 2, 2, 2, 1, 0, 0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset asserted in the middle of a blanking interval (cur=1 -> 2).
        @(negedge clk);
        bus.step_next = 1'b1;
        @(posedge clk);
        #1;
        chk("mb_busy", -2, 16'(bus.busy), 16'h1);
        @(negedge clk);
        bus.step_next = 1'b0;
        bus.mode_out  = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mb_active", -2, 16'(bus.active), 16'h1);
        chk("mb_leds", -2, 16'(bus.leds), 16'h1);
        chk("mb_out_final", -2, 16'(bus.out_final), 16'h0);
        chk("mb_busy_rst", -2, 16'(bus.busy), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mb_after_active", -2, 16'(bus.active), 16'h1);
        chk("mb_after_busy", -2, 16'(bus.busy), 16'h0);
        chk("mb_after_out", -2, 16'(bus.out_final), 16'h1);

        // Zero-blank build: switch lands on active directly.
        @(negedge clk);
        bus0.step_next = 1'b1;
        @(posedge clk);
        #1;
        chk("b0_active", -3, 16'(bus0.active), 16'h2);
        chk("b0_leds", -3, 16'(bus0.leds), 16'h2);
        chk("b0_busy", -3, 16'(bus0.busy), 16'h0);
        @(negedge clk);
        bus0.step_next = 1'b0;
        bus0.step_prev = 1'b1;
        @(posedge clk);
        #1;
        chk("b0_prev_active", -3, 16'(bus0.active), 16'h1);
        chk("b0_prev_busy", -3, 16'(bus0.busy), 16'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
